serdesphy_i2c_slave: RTL and testbench

SERDESPHY_I2C_SLAVE -- requirements
Module: serdesphy_i2c_slave

---
 rtl/serdesphy_i2c_slave_pkg.sv | 22 ++
 rtl/serdesphy_i2c_sync_edge.sv | 35 +++
 rtl/serdesphy_i2c_slave.sv | 179 +++++++++++++++++
 tb/tb_serdesphy_i2c_slave.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_i2c_slave_pkg.sv
// Shared types and constants for the SERDES PHY I2C slave.
// Holds the FSM state encoding, ACK/NACK levels and default address.
package serdesphy_i2c_slave_pkg;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;
  localparam logic       ACK              = 1'b0;
  localparam logic       NACK             = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RACK,
    S_WAIT_STOP
  } state_t;

endpackage

// File: rtl/serdesphy_i2c_sync_edge.sv
// Two-flop synchroniser plus history flop with rise/fall detection.
// Edges are held off until the pipeline holds real samples after reset.
module serdesphy_i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_h;
  logic [2:0] r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_h  <= 1'b1;
      r_v  <= 3'b000;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_h  <= r_s2;
      r_v  <= {r_v[1:0], 1'b1};
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_v[2] & r_s2 & ~r_h;
  assign o_fall = r_v[2] & ~r_s2 & r_h;

endmodule

// File: rtl/serdesphy_i2c_slave.sv
// I2C slave bridging a pad-level bus to an 8-bit CSR port.
// Supports pointer write, burst write and burst read with auto-increment.
module serdesphy_i2c_slave
  import serdesphy_i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_write_en,
  output logic       reg_read_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_last;
  logic [7:0] w_byte;

  state_t     r_state;
  logic [2:0] r_bitcnt;
  logic [6:0] r_shift;
  logic [7:0] r_tx;
  logic       r_rw;
  logic       r_ackph;
  logic       r_rd_d1;

  serdesphy_i2c_sync_edge u_scl (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (scl_i),
    .o_q    (w_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  serdesphy_i2c_sync_edge u_sda (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (sda_i),
    .o_q    (w_sda),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;
  assign w_last  = (r_bitcnt == 3'd7);
  assign w_byte  = {r_shift, w_sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bitcnt     <= 3'd0;
      r_shift      <= 7'd0;
      r_tx         <= 8'hFF;
      r_rw         <= 1'b0;
      r_ackph      <= 1'b0;
      r_rd_d1      <= 1'b0;
      sda_oe       <= 1'b0;
      reg_addr     <= 8'h00;
      reg_wdata    <= 8'h00;
      reg_write_en <= 1'b0;
      reg_read_en  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      reg_write_en <= 1'b0;
      reg_read_en  <= 1'b0;
      r_rd_d1      <= reg_read_en;
      if (r_rd_d1)
        r_tx <= reg_rdata;
      // Pointer advances the clk after the write strobe it addressed
      if (reg_write_en)
        reg_addr <= reg_addr + 8'd1;
      if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= 3'd0;
        r_ackph  <= 1'b0;
        sda_oe   <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_ackph <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_WAIT_STOP: begin
          end
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte[6:0];
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_last) begin
                r_ackph <= 1'b0;
                if (r_state == S_ADDR) begin
                  if (w_byte[7:1] == DEV_ADDR) begin
                    r_state     <= S_ADDR_ACK;
                    r_rw        <= w_byte[0];
                    busy        <= 1'b1;
                    reg_read_en <= w_byte[0];
                  end else begin
                    r_state <= S_WAIT_STOP;
                    busy    <= 1'b0;
                  end
                end else if (r_state == S_PTR) begin
                  reg_addr <= w_byte;
                  r_state  <= S_PTR_ACK;
                end else begin
                  reg_wdata    <= w_byte;
                  reg_write_en <= 1'b1;
                  r_state      <= S_WDATA_ACK;
                end
              end
            end
          end
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ackph) begin
                sda_oe  <= ~ACK;
                r_ackph <= 1'b1;
              end else begin
                r_ackph  <= 1'b0;
                r_bitcnt <= 3'd0;
                if (r_state == S_ADDR_ACK && r_rw) begin
                  r_state <= S_RDATA;
                  sda_oe  <= ~r_tx[7];
                  r_tx    <= {r_tx[6:0], 1'b1};
                end else begin
                  sda_oe  <= 1'b0;
                  r_state <= (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_last) begin
                r_state <= S_RACK;
                r_ackph <= 1'b0;
              end
            end else if (w_scl_fall) begin
              sda_oe <= ~r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b1};
            end
          end
          S_RACK: begin
            if (w_scl_fall) begin
              if (!r_ackph) begin
                sda_oe  <= 1'b0;
                r_ackph <= 1'b1;
              end else begin
                r_ackph <= 1'b0;
                r_state <= S_RDATA;
                sda_oe  <= ~r_tx[7];
                r_tx    <= {r_tx[6:0], 1'b1};
              end
            end else if (w_scl_rise && r_ackph) begin
              if (w_sda == NACK) begin
                r_state <= S_WAIT_STOP;
              end else begin
                reg_addr    <= reg_addr + 8'd1;
                reg_read_en <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serdesphy_i2c_slave.sv
// Bench for serdesphy_i2c_slave: bit-banged master, CSR model and
// a strobe scoreboard fed by expected-transaction queues.
module tb_serdesphy_i2c_slave;

  localparam int Q = 10;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write_en;
  logic       reg_read_en;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic [7:0] mem [256];

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t wq[$];
  logic [7:0] rq[$];

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  serdesphy_i2c_slave #(.DEV_ADDR(7'h50)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_i        (scl_m),
    .sda_i        (sda_line),
    .sda_oe       (sda_oe),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_write_en (reg_write_en),
    .reg_read_en  (reg_read_en),
    .reg_rdata    (reg_rdata),
    .busy         (busy)
  );

  always @(posedge clk)
    if (reg_read_en) reg_rdata <= mem[reg_addr];

  // Scoreboard monitor: every strobe must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] ra;
    if (reg_write_en && reg_read_en) begin
      n_chk++; n_fail++;
      $display("FAIL strobe_overlap: both strobes high, required at most one");
    end
    if (reg_write_en) begin
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h, required no write",
                 reg_addr, reg_wdata);
      end else begin
        e = wq.pop_front();
        if (reg_addr !== e.a || reg_wdata !== e.d) begin
          n_fail++;
          $display("FAIL write: addr %h data %h, required addr %h data %h",
                   reg_addr, reg_wdata, e.a, e.d);
        end
      end
    end
    if (reg_read_en) begin
      n_chk++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: addr %h, required no read", reg_addr);
      end else begin
        ra = rq.pop_front();
        if (reg_addr !== ra) begin
          n_fail++;
          $display("FAIL read: addr %h, required %h", reg_addr, ra);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    wq.push_back(e);
  endtask

  task automatic qw();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b0; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b1; qw();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; qw();
    scl_m = 1'b1; qw();
    qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    b = sda_line; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic wbyte(input logic [7:0] b, input logic exp_ack,
                       input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
    chk(nm, {7'd0, a}, {7'd0, exp_ack});
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) rbit(b[i]);
    wbit(mack);
  endtask

  initial begin
    logic [7:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h06] = 8'hA5;
    mem[8'hFF] = 8'h3C;
    mem[8'h00] = 8'hC3;

    repeat (4) @(posedge clk);
    #1;
    chk("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_ptr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_strobes", {6'd0, reg_write_en, reg_read_en}, 8'h00);
    rst_n = 1'b1;
    qw();

    // single write
    push_w(8'h01, 8'h05);
    i2c_start();
    wbyte(8'hA0, 1'b0, "w1_addr_ack");
    chk("w1_busy", {7'd0, busy}, 8'h01);
    wbyte(8'h01, 1'b0, "w1_ptr_ack");
    wbyte(8'h05, 1'b0, "w1_data_ack");
    i2c_stop();
    qw();
    chk("w1_busy_end", {7'd0, busy}, 8'h00);
    chk("w1_ptr", reg_addr, 8'h02);

    // burst write
    push_w(8'h03, 8'h01);
    push_w(8'h04, 8'h88);
    i2c_start();
    wbyte(8'hA0, 1'b0, "bw_addr_ack");
    wbyte(8'h03, 1'b0, "bw_ptr_ack");
    wbyte(8'h01, 1'b0, "bw_d0_ack");
    wbyte(8'h88, 1'b0, "bw_d1_ack");
    i2c_stop();
    qw();
    chk("bw_ptr", reg_addr, 8'h05);

    // read with repeated start, master NACK
    rq.push_back(8'h06);
    i2c_start();
    wbyte(8'hA0, 1'b0, "rd_waddr_ack");
    wbyte(8'h06, 1'b0, "rd_ptr_ack");
    i2c_start();
    wbyte(8'hA1, 1'b0, "rd_raddr_ack");
    rbyte(1'b1, d);
    chk("rd_data", d, 8'hA5);
    chk("rd_released", {7'd0, sda_oe}, 8'h00);
    i2c_stop();
    qw();
    chk("rd_ptr", reg_addr, 8'h06);

    // address mismatch
    i2c_start();
    wbyte(8'hA2, 1'b1, "mm_addr_nack");
    chk("mm_busy", {7'd0, busy}, 8'h00);
    wbyte(8'h33, 1'b1, "mm_data_nack");
    i2c_stop();
    qw();
    chk("mm_ptr", reg_addr, 8'h06);

    // pointer wrap on burst read
    rq.push_back(8'hFF);
    rq.push_back(8'h00);
    i2c_start();
    wbyte(8'hA0, 1'b0, "wr_waddr_ack");
    wbyte(8'hFF, 1'b0, "wr_ptr_ack");
    i2c_start();
    wbyte(8'hA1, 1'b0, "wr_raddr_ack");
    rbyte(1'b0, d);
    chk("wr_d0", d, 8'h3C);
    rbyte(1'b1, d);
    chk("wr_d1", d, 8'hC3);
    i2c_stop();
    qw();
    chk("wr_ptr", reg_addr, 8'h00);

    // STOP mid-byte aborts the write
    i2c_start();
    wbyte(8'hA0, 1'b0, "ab_addr_ack");
    wbyte(8'h40, 1'b0, "ab_ptr_ack");
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    i2c_stop();
    qw();
    chk("ab_ptr", reg_addr, 8'h40);

    // reset during the 4th data bit
    i2c_start();
    wbyte(8'hA0, 1'b0, "rs_addr_ack");
    wbyte(8'h10, 1'b0, "rs_ptr_ack");
    wbit(1'b1); wbit(1'b0); wbit(1'b1);
    sda_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rs_sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("rs_busy", {7'd0, busy}, 8'h00);
    chk("rs_ptr", reg_addr, 8'h00);
    rst_n = 1'b1;
    qw();
    i2c_stop();
    qw();
    chk("rs_ptr_after", reg_addr, 8'h00);
    push_w(8'h20, 8'h77);
    i2c_start();
    wbyte(8'hA0, 1'b0, "rs2_addr_ack");
    wbyte(8'h20, 1'b0, "rs2_ptr_ack");
    wbyte(8'h77, 1'b0, "rs2_data_ack");
    i2c_stop();
    qw();
    chk("rs2_ptr", reg_addr, 8'h21);

    repeat (20) @(posedge clk);
    #1;
    chk("wq_drained", 8'(wq.size()), 8'h00);
    chk("rq_drained", 8'(rq.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
